// File: rtl/bus_cycle_arbiter_if.sv
// Bundle of client handshake signals and system-bus control outputs for
// bus_cycle_arbiter. The READY wait-state input exists only when the
// BUSARB_READY_EN macro is defined. The shared Data bus is kept as a direct
// inout port of the arbiter so the tri-state pad stays at a module boundary.
interface bus_cycle_arbiter_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 8
);
   // client 0
   logic              REQ0;
   logic              WE0;
   logic              IOM0;
   logic [ADDR_W-1:0] ADDR0;
   logic [DATA_W-1:0] WDATA0;
   logic              DONE0;
   // client 1
   logic              REQ1;
   logic              WE1;
   logic              IOM1;
   logic [ADDR_W-1:0] ADDR1;
   logic [DATA_W-1:0] WDATA1;
   logic              DONE1;
   // shared return data and bus control
   logic [DATA_W-1:0] RDATA;
   logic [ADDR_W-1:0] Address;
   logic              ALE;
   logic              RD;
   logic              WR;
   logic              IOM;
   logic              CS0;
   logic              CS1;
`ifdef BUSARB_READY_EN
   logic              READY;

   modport master (
      input  REQ0, WE0, IOM0, ADDR0, WDATA0, REQ1, WE1, IOM1, ADDR1, WDATA1, READY,
      output DONE0, DONE1, RDATA, Address, ALE, RD, WR, IOM, CS0, CS1
   );
   modport slave (
      output REQ0, WE0, IOM0, ADDR0, WDATA0, REQ1, WE1, IOM1, ADDR1, WDATA1, READY,
      input  DONE0, DONE1, RDATA, Address, ALE, RD, WR, IOM, CS0, CS1
   );
`else
   modport master (
      input  REQ0, WE0, IOM0, ADDR0, WDATA0, REQ1, WE1, IOM1, ADDR1, WDATA1,
      output DONE0, DONE1, RDATA, Address, ALE, RD, WR, IOM, CS0, CS1
   );
   modport slave (
      output REQ0, WE0, IOM0, ADDR0, WDATA0, REQ1, WE1, IOM1, ADDR1, WDATA1,
      input  DONE0, DONE1, RDATA, Address, ALE, RD, WR, IOM, CS0, CS1
   );
`endif
endinterface

// File: rtl/bus_cycle_arbiter.sv
// bus_cycle_arbiter: round-robin two-client bus master running T1-T4 bus
// cycles. Optional wait states (TW state, READY input) are enabled by the
// BUSARB_READY_EN macro. All bus outputs are registered from the next state.
module bus_cycle_arbiter #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 8
) (
   input  logic                CLK,
   input  logic                RESET,
   bus_cycle_arbiter_if.master bus,
   inout  wire  [DATA_W-1:0]   Data
);

`ifdef BUSARB_READY_EN
   typedef enum logic [2:0] {TI = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, TW = 3'd5} state_t;
`else
   typedef enum logic [2:0] {TI = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} state_t;
`endif

   state_t            state_r, next_state_s;
   logic              elig0_s, elig1_s, grant_valid_s, win_s;
   logic              capture_s, strobe_s;
   logic              last_r, served_r, we_r;
   logic [DATA_W-1:0] wdata_r, rdata_r;
   logic [ADDR_W-1:0] address_r;
   logic              iom_r, ale_r, rd_r, wr_r, cs0_r, cs1_r;
   logic              done0_r, done1_r, data_oe_r;

   // Round-robin arbitration; the client being completed in T4 is not eligible.
   always_comb begin
      elig0_s       = 1'b0;
      elig1_s       = 1'b0;
      win_s         = 1'b0;
      if (state_r == TI || state_r == T4) begin
         elig0_s = bus.REQ0 && !(state_r == T4 && served_r == 1'b0);
         elig1_s = bus.REQ1 && !(state_r == T4 && served_r == 1'b1);
      end else begin
         elig0_s = 1'b0;
         elig1_s = 1'b0;
      end
      grant_valid_s = elig0_s | elig1_s;
      if (elig0_s && elig1_s) begin
         win_s = ~last_r;
      end else if (elig1_s) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   // Next-state decode of the bus cycle sequencer.
   always_comb begin
      next_state_s = TI;
      case (state_r)
         TI:      next_state_s = grant_valid_s ? T1 : TI;
         T1:      next_state_s = T2;
         T2:      next_state_s = T3;
`ifdef BUSARB_READY_EN
         T3:      next_state_s = bus.READY ? T4 : TW;
         TW:      next_state_s = bus.READY ? T4 : TW;
`else
         T3:      next_state_s = T4;
`endif
         T4:      next_state_s = grant_valid_s ? T1 : TI;
         default: next_state_s = TI;
      endcase
   end

   // Read data is sampled on the edge that leaves T3/TW for T4; strobe spans T2..TW.
   always_comb begin
      capture_s = (state_r != T4) && (state_r != TI) && (state_r != T1) &&
                  (state_r != T2) && (next_state_s == T4);
      strobe_s  = (next_state_s != TI) && (next_state_s != T1) && (next_state_s != T4);
   end

   // State, request latch and registered bus outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r   <= TI;
         last_r    <= 1'b1;
         served_r  <= 1'b0;
         we_r      <= 1'b0;
         wdata_r   <= {DATA_W{1'b0}};
         rdata_r   <= {DATA_W{1'b0}};
         address_r <= {ADDR_W{1'b0}};
         iom_r     <= 1'b0;
         ale_r     <= 1'b0;
         rd_r      <= 1'b1;
         wr_r      <= 1'b1;
         cs0_r     <= 1'b0;
         cs1_r     <= 1'b0;
         done0_r   <= 1'b0;
         done1_r   <= 1'b0;
         data_oe_r <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         ale_r     <= (next_state_s == T1);
         rd_r      <= !(strobe_s && !we_r);
         wr_r      <= !(strobe_s && we_r);
         data_oe_r <= strobe_s && we_r;
         done0_r   <= capture_s && (served_r == 1'b0);
         done1_r   <= capture_s && (served_r == 1'b1);
         if (capture_s && !we_r) begin
            rdata_r <= Data;
         end
         if (next_state_s == T1) begin
            last_r    <= win_s;
            served_r  <= win_s;
            we_r      <= win_s ? bus.WE1    : bus.WE0;
            wdata_r   <= win_s ? bus.WDATA1 : bus.WDATA0;
            address_r <= win_s ? bus.ADDR1  : bus.ADDR0;
            iom_r     <= win_s ? bus.IOM1   : bus.IOM0;
            cs0_r     <= win_s ? (!bus.IOM1 && !bus.ADDR1[ADDR_W-1]) : (!bus.IOM0 && !bus.ADDR0[ADDR_W-1]);
            cs1_r     <= win_s ? (!bus.IOM1 &&  bus.ADDR1[ADDR_W-1]) : (!bus.IOM0 &&  bus.ADDR0[ADDR_W-1]);
         end else if (next_state_s == TI) begin
            cs0_r <= 1'b0;
            cs1_r <= 1'b0;
         end
      end
   end

   assign Data        = data_oe_r ? wdata_r : {DATA_W{1'bz}};
   assign bus.DONE0   = done0_r;
   assign bus.DONE1   = done1_r;
   assign bus.RDATA   = rdata_r;
   assign bus.Address = address_r;
   assign bus.ALE     = ale_r;
   assign bus.RD      = rd_r;
   assign bus.WR      = wr_r;
   assign bus.IOM     = iom_r;
   assign bus.CS0     = cs0_r;
   assign bus.CS1     = cs1_r;

endmodule
